neuron_input_loader: RTL and testbench

Byte-stream front end for the layer-1 neuron. Accepts a framed byte stream over a valid/ready handshake and unpacks it into the neuron's 49 signed 8-bit weights and 49 binary pixels. It holds those values stable while the two-stage neuron computes, then captures the neuron's signed 8-bit result and offers it downstream on a valid/ready handshake. It is the writer/reader counterpart of the neuron: it drives every neuron input and consumes the neuron output.

---
 rtl/neuron_pkg.sv | 31 +++
 rtl/pixel_byte_unpacker.sv | 32 +++
 rtl/neuron_input_loader.sv | 174 +++++++++++++++++
 tb/tb_neuron_input_loader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg
// Shared constants, state encoding and helpers for the layer-1 neuron input loader.
//   N_INPUTS       : pixel/weight pairs fed to the neuron
//   W_WIDTH        : weight and result width (two's complement)
//   PIX_BYTES      : stream bytes carrying the packed pixel bits
//   NEURON_LATENCY : register stages between neuron inputs and neuron output
// No configuration macros are used in this file.
package neuron_pkg;

    localparam int N_INPUTS       = 49;
    localparam int W_WIDTH        = 8;
    localparam int PIX_BYTES      = (N_INPUTS + 7) / 8;
    localparam int NEURON_LATENCY = 2;

    localparam int WCNT_W = $clog2(N_INPUTS);
    localparam int PCNT_W = $clog2(PIX_BYTES);
    localparam int WAIT_W = $clog2(NEURON_LATENCY + 1);

    typedef enum logic [1:0] {
        LOAD_W,
        LOAD_P,
        WAIT,
        RESULT
    } loaderState_t;

    // Bit position of the least significant bit of weight k in the packed weight bus.
    function automatic int weightLsb(input int k);
        return k * W_WIDTH;
    endfunction

endpackage

// File: rtl/pixel_byte_unpacker.sv
// pixel_byte_unpacker
// Merges one stream byte into the packed pixel vector: byte j lands on pixels
// [8j+7:8j], LSB first. Bit positions at or beyond N_INPUTS do not exist in the
// vector, so the unused high bits of the last pixel byte simply fall away.
// Ports:
//   i_pixels  : current pixel vector
//   i_wrEn    : merge i_byte this cycle
//   i_byteIdx : pixel byte index j
//   i_byte    : stream byte
//   o_pixels  : updated pixel vector (equals i_pixels when i_wrEn is low)
// No configuration macros are used in this file.
module pixel_byte_unpacker
    import neuron_pkg::*;
(
    input  logic [N_INPUTS-1:0] i_pixels,
    input  logic                i_wrEn,
    input  logic [PCNT_W-1:0]   i_byteIdx,
    input  logic [7:0]          i_byte,
    output logic [N_INPUTS-1:0] o_pixels
);

    // Walk the real pixel positions only; that is what masks the missing indices.
    always_comb begin
        o_pixels = i_pixels;
        for (int b = 0; b < N_INPUTS; b++) begin
            if (i_wrEn && ((b / 8) == int'(i_byteIdx))) begin
                o_pixels[b] = i_byte[b % 8];
            end
        end
    end

endmodule

// File: rtl/neuron_input_loader.sv
// neuron_input_loader
// Byte-stream front end for the layer-1 neuron. Unpacks a framed stream
// (N_INPUTS weight bytes, then PIX_BYTES pixel bytes) into the neuron inputs,
// holds them while the neuron pipeline settles, then captures the neuron result
// and offers it downstream.
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   in_valid/in_ready    : stream handshake, in_data is the stream byte
//   weights, pixels      : neuron inputs, change only on accepted bytes
//   neuron_out           : neuron result, captured raw
//   res_valid/res_ready  : result handshake, res_data is the captured result
//   busy                 : low only when idle at the start of a full frame
// Configuration macro: LOADER_WEIGHT_KEEP_EN keeps the first frame's weights and
// makes every later frame pixel bytes only.
module neuron_input_loader
    import neuron_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_data,
    output logic [N_INPUTS*W_WIDTH-1:0] weights,
    output logic [N_INPUTS-1:0]         pixels,
    input  logic [W_WIDTH-1:0]          neuron_out,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [W_WIDTH-1:0]          res_data,
    output logic                        busy
);

    localparam logic [WCNT_W-1:0] W_LAST_IDX = WCNT_W'(N_INPUTS - 1);
    localparam logic [PCNT_W-1:0] P_LAST_IDX = PCNT_W'(PIX_BYTES - 1);
    localparam logic [WAIT_W-1:0] WAIT_DONE  = WAIT_W'(NEURON_LATENCY);

    loaderState_t r_state;
    loaderState_t w_nextState;
    loaderState_t w_returnState;

    logic [WCNT_W-1:0]           r_wCount;
    logic [PCNT_W-1:0]           r_pCount;
    logic [WAIT_W-1:0]           r_waitCount;
    logic [N_INPUTS*W_WIDTH-1:0] r_weights;
    logic [N_INPUTS-1:0]         r_pixels;
    logic                        r_resValid;
    logic [W_WIDTH-1:0]          r_resData;

    logic                        w_inReady;
    logic                        w_pixWrEn;
    logic [N_INPUTS-1:0]         w_nextPixels;

`ifdef LOADER_WEIGHT_KEEP_EN
    logic r_weightsLoaded;

    // Once a whole frame has been loaded the weights are considered fixed; only reset forgets them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_weightsLoaded <= 1'b0;
        end else if ((r_state == LOAD_P) && in_valid && (r_pCount == P_LAST_IDX)) begin
            r_weightsLoaded <= 1'b1;
        end
    end

    assign w_returnState = r_weightsLoaded ? LOAD_P : LOAD_W;
`else
    assign w_returnState = LOAD_W;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD_W;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; in_ready comes from the state register alone.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        case (r_state)
            LOAD_W: begin
                w_inReady = 1'b1;
                if (in_valid && (r_wCount == W_LAST_IDX)) begin
                    w_nextState = LOAD_P;
                end
            end
            LOAD_P: begin
                w_inReady = 1'b1;
                if (in_valid && (r_pCount == P_LAST_IDX)) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (r_waitCount == WAIT_DONE) begin
                    w_nextState = RESULT;
                end
            end
            RESULT: begin
                if (r_resValid && res_ready) begin
                    w_nextState = w_returnState;
                end
            end
            default: begin
                w_nextState = LOAD_W;
            end
        endcase
    end

    assign w_pixWrEn = (r_state == LOAD_P) && in_valid;

    pixel_byte_unpacker u_unpacker (
        .i_pixels  (r_pixels),
        .i_wrEn    (w_pixWrEn),
        .i_byteIdx (r_pCount),
        .i_byte    (in_data),
        .o_pixels  (w_nextPixels)
    );

    // Datapath: byte capture, frame counters, latency wait and result capture.
    // The wait counter runs 0..NEURON_LATENCY so the capture lands one edge after
    // the neuron sum register has seen the final inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wCount    <= '0;
            r_pCount    <= '0;
            r_waitCount <= '0;
            r_weights   <= '0;
            r_pixels    <= '0;
            r_resValid  <= 1'b0;
            r_resData   <= '0;
        end else begin
            r_pixels <= w_nextPixels;
            case (r_state)
                LOAD_W: begin
                    if (in_valid) begin
                        r_weights[weightLsb(int'(r_wCount)) +: W_WIDTH] <= in_data;
                        r_wCount <= (r_wCount == W_LAST_IDX) ? '0 : r_wCount + WCNT_W'(1);
                    end
                end
                LOAD_P: begin
                    if (in_valid) begin
                        r_pCount    <= (r_pCount == P_LAST_IDX) ? '0 : r_pCount + PCNT_W'(1);
                        r_waitCount <= '0;
                    end
                end
                WAIT: begin
                    if (r_waitCount == WAIT_DONE) begin
                        r_resData  <= neuron_out;
                        r_resValid <= 1'b1;
                    end else begin
                        r_waitCount <= r_waitCount + WAIT_W'(1);
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        r_resValid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = w_inReady;
    assign weights   = r_weights;
    assign pixels    = r_pixels;
    assign res_valid = r_resValid;
    assign res_data  = r_resData;
    assign busy      = !((r_state == LOAD_W) && (r_wCount == '0));

endmodule

// File: tb/tb_neuron_input_loader.sv
// tb_neuron_input_loader
// Drives framed byte streams into neuron_input_loader, closes the loop through a
// two-stage neuron model, and compares every output each cycle against a
// frame-level model of the loader. A few literal expectations pin that model.
// Optional build macro: LOADER_WEIGHT_KEEP_EN.
module tb_neuron_input_loader;
    import neuron_pkg::*;

    localparam int FRAME_BYTES = N_INPUTS + PIX_BYTES;
    localparam int WBITS = N_INPUTS * W_WIDTH;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_data;
    logic [WBITS-1:0]    weights;
    logic [N_INPUTS-1:0] pixels;
    logic [W_WIDTH-1:0]  neuron_out;
    logic                res_valid;
    logic                res_ready;
    logic [W_WIDTH-1:0]  res_data;
    logic                busy;

    int errors = 0;
    int checks = 0;
    int dutXfers = 0;

    always #5 clk = ~clk;

    neuron_input_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .weights    (weights),
        .pixels     (pixels),
        .neuron_out (neuron_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy)
    );

    // Neuron stand-in: gated products registered, then their wrapped sum registered.
    logic [7:0] prodReg [N_INPUTS] = '{default: 8'h00};
    logic [7:0] sumReg = 8'h00;

    always @(posedge clk) begin
        for (int k = 0; k < N_INPUTS; k++) begin
            prodReg[k] <= pixels[k] ? weights[weightLsb(k) +: 8] : 8'h00;
        end
    end

    always @(posedge clk) begin : neuronSum
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < N_INPUTS; k++) s = s + prodReg[k];
        sumReg <= s;
    end

    assign neuron_out = sumReg;

    // Frame-level loader model: a byte image of the last frame plus a position.
    logic [7:0] mFrame [FRAME_BYTES] = '{default: 8'h00};
    int         mPos = 0;
    int         mWait = -1;
    bit         mResValid = 1'b0;
    logic [7:0] mResData = 8'h00;
    bit         mKeep = 1'b0;
    bit         modelLive = 1'b0;

    function automatic logic [WBITS-1:0] expWeights();
        logic [WBITS-1:0] v;
        v = '0;
        for (int k = 0; k < N_INPUTS; k++) v[weightLsb(k) +: 8] = mFrame[k];
        return v;
    endfunction

    function automatic logic [N_INPUTS-1:0] expPixels();
        logic [N_INPUTS-1:0] v;
        for (int i = 0; i < N_INPUTS; i++) v[i] = mFrame[N_INPUTS + i / 8][i % 8];
        return v;
    endfunction

    function automatic logic [7:0] expectedResult();
        int s;
        logic [N_INPUTS-1:0] p;
        s = 0;
        p = expPixels();
        for (int k = 0; k < N_INPUTS; k++) if (p[k]) s += int'($signed(mFrame[k]));
        return s[7:0];
    endfunction

    always @(posedge clk) begin
        modelLive = 1'b1;
        if (rst) begin
            for (int i = 0; i < FRAME_BYTES; i++) mFrame[i] = 8'h00;
            mPos = 0; mWait = -1; mResValid = 1'b0; mResData = 8'h00; mKeep = 1'b0;
        end else if (mResValid) begin
            if (res_ready) begin
                mResValid = 1'b0;
                mPos = mKeep ? N_INPUTS : 0;
            end
        end else if (mWait >= 0) begin
            if (mWait == NEURON_LATENCY) begin
                mResValid = 1'b1;
                mResData = expectedResult();
                mWait = -1;
            end else begin
                mWait++;
            end
        end else if (in_valid) begin
            mFrame[mPos] = in_data;
            mPos++;
            if (mPos == FRAME_BYTES) begin
                mPos = 0;
                mWait = 0;
`ifdef LOADER_WEIGHT_KEEP_EN
                mKeep = 1'b1;
`endif
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) dutXfers++;
    end

    task automatic checkOutput(input string name, input logic [WBITS-1:0] act, input logic [WBITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (modelLive) begin
            bit accepting;
            accepting = !mResValid && (mWait < 0);
            checkOutput("in_ready", WBITS'(in_ready), WBITS'(accepting));
            checkOutput("busy", WBITS'(busy), WBITS'(!(accepting && mPos == 0)));
            checkOutput("res_valid", WBITS'(res_valid), WBITS'(mResValid));
            checkOutput("res_data", WBITS'(res_data), WBITS'(mResData));
            checkOutput("weights", weights, expWeights());
            checkOutput("pixels", WBITS'(pixels), WBITS'(expPixels()));
        end
    end

    logic [7:0] frameW [N_INPUTS];
    logic [7:0] frameP [PIX_BYTES];

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got 0 want 1");
        end
        in_valid = 1'b1;
        in_data = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic sendFrame(input int gap);
        for (int k = 0; k < N_INPUTS; k++) applyStimulus(frameW[k], gap);
        for (int j = 0; j < PIX_BYTES; j++) applyStimulus(frameP[j], gap);
    endtask

    task automatic waitResult(output int n);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL res_valid_timeout: got 0 want 1");
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", WBITS'(in_ready), WBITS'(1));
        checkOutput("reset_busy", WBITS'(busy), '0);
        checkOutput("reset_weights", weights, '0);
        checkOutput("reset_res_data", WBITS'(res_data), '0);
        rst = 1'b0;

        $display("[TB] all-ones frame");
        for (int k = 0; k < N_INPUTS; k++) frameW[k] = 8'h01;
        for (int j = 0; j < PIX_BYTES; j++) frameP[j] = 8'hFF;
        frameP[PIX_BYTES-1] = 8'h01;
        sendFrame(0);
        waitResult(lat);
        checkOutput("latency", WBITS'(lat), WBITS'(3));
        checkOutput("sum49", WBITS'(res_data), WBITS'(8'h31));
        @(negedge clk);

        $display("[TB] single -128 weight");
        doReset();
        for (int k = 0; k < N_INPUTS; k++) frameW[k] = 8'h00;
        frameW[0] = 8'h80;
        for (int j = 0; j < PIX_BYTES; j++) frameP[j] = 8'h00;
        frameP[0] = 8'h01;
        sendFrame(0);
        waitResult(lat);
        checkOutput("neg128", WBITS'(res_data), WBITS'(8'h80));
        checkOutput("w0_held", WBITS'(weights[7:0]), WBITS'(8'h80));
        @(negedge clk);

        $display("[TB] toggling in_valid");
        doReset();
        for (int k = 0; k < N_INPUTS; k++) frameW[k] = 8'h01;
        for (int j = 0; j < PIX_BYTES; j++) frameP[j] = 8'hFF;
        frameP[PIX_BYTES-1] = 8'h01;
        dutXfers = 0;
        sendFrame(1);
        waitResult(lat);
        checkOutput("toggle_xfers", WBITS'(dutXfers), WBITS'(56));
        checkOutput("toggle_sum", WBITS'(res_data), WBITS'(8'h31));
        @(negedge clk);

        $display("[TB] result hold with res_ready low");
        doReset();
        for (int k = 0; k < N_INPUTS; k++) frameW[k] = 8'(k * 5 - 100);
        frameP = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'hFF};
        res_ready = 1'b0;
        sendFrame(0);
        waitResult(lat);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data = 8'hAA;
            @(negedge clk);
            checkOutput("hold_valid", WBITS'(res_valid), WBITS'(1));
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("released", WBITS'(res_valid), '0);

        $display("[TB] reset mid-frame");
        doReset();
        for (int k = 0; k < 30; k++) applyStimulus(8'h11, 0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h77;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        checkOutput("midrst_weights", weights, '0);
        checkOutput("midrst_busy", WBITS'(busy), '0);
        for (int k = 0; k < N_INPUTS; k++) frameW[k] = 8'(k - 24);
        for (int j = 0; j < PIX_BYTES; j++) frameP[j] = 8'hFF;
        sendFrame(0);
        waitResult(lat);
        checkOutput("after_rst_sum", WBITS'(res_data), WBITS'(8'h00));
        @(negedge clk);

        $display("[TB] pixel-only second frame");
        doReset();
        for (int k = 0; k < N_INPUTS; k++) frameW[k] = 8'h01;
        for (int j = 0; j < PIX_BYTES; j++) frameP[j] = 8'hFF;
        sendFrame(0);
        waitResult(lat);
        @(negedge clk);
        for (int j = 0; j < PIX_BYTES; j++) applyStimulus(8'h00, 0);
`ifdef LOADER_WEIGHT_KEEP_EN
        waitResult(lat);
        checkOutput("keep_res", WBITS'(res_data), '0);
        checkOutput("keep_w", WBITS'(weights[7:0]), WBITS'(8'h01));
`else
        @(negedge clk);
        @(negedge clk);
        checkOutput("nokeep_valid", WBITS'(res_valid), '0);
        checkOutput("nokeep_busy", WBITS'(busy), WBITS'(1));
        checkOutput("nokeep_ready", WBITS'(in_ready), WBITS'(1));
        checkOutput("nokeep_low", WBITS'(weights[55:0]), '0);
        checkOutput("nokeep_w7", WBITS'(weights[63:56]), WBITS'(8'h01));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
